// File: rtl/latency_data_memory_if.sv
// Request/response bus for latency_data_memory: one request in flight,
// response held until the consumer takes it.
interface latency_data_memory_if #(
    parameter int DATA_WIDTH = 32
);
    logic                    req_valid;
    logic                    req_ready;
    logic                    req_write;
    logic [31:0]             addr;
    logic [DATA_WIDTH-1:0]   din;
    logic [DATA_WIDTH/8-1:0] byte_en;
    logic                    resp_valid;
    logic                    resp_ready;
    logic [DATA_WIDTH-1:0]   resp_dout;
    logic                    resp_err;

    modport master (
        output req_valid, req_write, addr, din, byte_en, resp_ready,
        input  req_ready, resp_valid, resp_dout, resp_err
    );

    modport slave (
        input  req_valid, req_write, addr, din, byte_en, resp_ready,
        output req_ready, resp_valid, resp_dout, resp_err
    );
endinterface

// File: rtl/latency_data_memory.sv
// Single-port data memory with a fixed request-to-response latency and byte enables.
// Optional feature macro: DMEM_MISALIGN_CHECK_EN (flag and suppress misaligned accesses).
module latency_data_memory #(
    parameter int MEM_DEPTH  = 16384,
    parameter int DATA_WIDTH = 32,
    parameter int LATENCY    = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    latency_data_memory_if.slave   bus
);
    localparam int NB    = DATA_WIDTH / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [3:0] LAT_C = 4'(LATENCY);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                  state_r;
    state_t                  state_nx_s;
    logic [3:0]              cnt_r;
    logic                    wr_r;
    logic [31:0]             addr_r;
    logic [DATA_WIDTH-1:0]   din_r;
    logic [NB-1:0]           be_r;
    logic                    req_ready_r;
    logic                    resp_valid_r;
    logic                    resp_err_r;
    logic [DATA_WIDTH-1:0]   resp_dout_r;
    logic [DATA_WIDTH-1:0]   mem_r [MEM_DEPTH];

    logic                    accept_s;
    logic                    commit_s;
    logic                    misalign_s;
    logic [IDX_W-1:0]        idx_s;

    // Handshake qualifiers and the wrapped word index of the latched address
    always_comb begin
        accept_s = (state_r == IDLE) && bus.req_valid;
        commit_s = (state_r == BUSY) && (cnt_r == LAT_C);
        idx_s    = IDX_W'((addr_r >> OFF_W) % 32'(MEM_DEPTH));
    end

`ifdef DMEM_MISALIGN_CHECK_EN
    // Any nonzero byte offset within the word marks the access as misaligned
    always_comb begin
        misalign_s = |addr_r[OFF_W-1:0];
    end
`else
    // Byte offset is ignored; the error path is never taken
    always_comb begin
        misalign_s = 1'b0;
    end
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.req_valid) begin
                    state_nx_s = BUSY;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            BUSY: begin
                if (cnt_r == LAT_C) begin
                    state_nx_s = RESP;
                end else begin
                    state_nx_s = BUSY;
                end
            end
            RESP: begin
                if (bus.resp_ready) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = RESP;
                end
            end
            default: state_nx_s = IDLE;
        endcase
    end

    // Request capture on acceptance
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_r   <= 1'b0;
            addr_r <= 32'd0;
            din_r  <= '0;
            be_r   <= '0;
        end else if (accept_s) begin
            wr_r   <= bus.req_write;
            addr_r <= bus.addr;
            din_r  <= bus.din;
            be_r   <= bus.byte_en;
        end
    end

    // Latency counter: 1 on the acceptance edge, reaches LATENCY on the commit edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= 4'd0;
        end else if (accept_s) begin
            cnt_r <= 4'd1;
        end else if ((state_r == BUSY) && !commit_s) begin
            cnt_r <= cnt_r + 4'd1;
        end else begin
            cnt_r <= 4'd0;
        end
    end

    // Registered outputs; response data is zero whenever no response is presented
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_ready_r  <= 1'b1;
            resp_valid_r <= 1'b0;
            resp_err_r   <= 1'b0;
            resp_dout_r  <= '0;
        end else begin
            req_ready_r  <= (state_nx_s == IDLE);
            resp_valid_r <= (state_nx_s == RESP);
            if (commit_s) begin
                resp_err_r <= misalign_s;
                if (wr_r || misalign_s) begin
                    resp_dout_r <= '0;
                end else begin
                    resp_dout_r <= mem_r[idx_s];
                end
            end else if ((state_r == RESP) && bus.resp_ready) begin
                resp_err_r  <= 1'b0;
                resp_dout_r <= '0;
            end
        end
    end

    // Array write on the commit edge; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (commit_s && wr_r && !misalign_s) begin
            for (int b = 0; b < NB; b++) begin
                if (be_r[b]) begin
                    mem_r[idx_s][b*8 +: 8] <= din_r[b*8 +: 8];
                end
            end
        end
    end

    assign bus.req_ready  = req_ready_r;
    assign bus.resp_valid = resp_valid_r;
    assign bus.resp_err   = resp_err_r;
    assign bus.resp_dout  = resp_dout_r;
endmodule

// File: tb/tb_latency_data_memory.sv
// Directed bench for latency_data_memory: three configurations share one stimulus
// path, selected by sel_v (0: 32b/L4, 1: 32b/L15/depth16, 2: 64b/L1).
module tb_latency_data_memory;
    logic        clk = 1'b0;
    logic        reset;
    int          sel_v;
    logic        req_valid_v;
    logic        req_write_v;
    logic [31:0] addr_v;
    logic [63:0] din_v;
    logic [7:0]  be_v;
    logic        resp_ready_v;

    logic        req_ready_m;
    logic        resp_valid_m;
    logic        resp_err_m;
    logic [63:0] dout_m;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    latency_data_memory_if #(.DATA_WIDTH(32)) if_a ();
    latency_data_memory_if #(.DATA_WIDTH(32)) if_b ();
    latency_data_memory_if #(.DATA_WIDTH(64)) if_c ();

    assign if_a.req_valid  = req_valid_v && (sel_v == 0);
    assign if_a.resp_ready = resp_ready_v && (sel_v == 0);
    assign if_a.req_write  = req_write_v;
    assign if_a.addr       = addr_v;
    assign if_a.din        = din_v[31:0];
    assign if_a.byte_en    = be_v[3:0];

    assign if_b.req_valid  = req_valid_v && (sel_v == 1);
    assign if_b.resp_ready = resp_ready_v && (sel_v == 1);
    assign if_b.req_write  = req_write_v;
    assign if_b.addr       = addr_v;
    assign if_b.din        = din_v[31:0];
    assign if_b.byte_en    = be_v[3:0];

    assign if_c.req_valid  = req_valid_v && (sel_v == 2);
    assign if_c.resp_ready = resp_ready_v && (sel_v == 2);
    assign if_c.req_write  = req_write_v;
    assign if_c.addr       = addr_v;
    assign if_c.din        = din_v;
    assign if_c.byte_en    = be_v;

    latency_data_memory #(.MEM_DEPTH(16384), .DATA_WIDTH(32), .LATENCY(4)) dut_a (
        .clk(clk), .reset(reset), .bus(if_a)
    );
    latency_data_memory #(.MEM_DEPTH(16), .DATA_WIDTH(32), .LATENCY(15)) dut_b (
        .clk(clk), .reset(reset), .bus(if_b)
    );
    latency_data_memory #(.MEM_DEPTH(64), .DATA_WIDTH(64), .LATENCY(1)) dut_c (
        .clk(clk), .reset(reset), .bus(if_c)
    );

    always_comb begin
        req_ready_m  = 1'b0;
        resp_valid_m = 1'b0;
        resp_err_m   = 1'b0;
        dout_m       = 64'd0;
        case (sel_v)
            0: begin
                req_ready_m  = if_a.req_ready;
                resp_valid_m = if_a.resp_valid;
                resp_err_m   = if_a.resp_err;
                dout_m       = {32'd0, if_a.resp_dout};
            end
            1: begin
                req_ready_m  = if_b.req_ready;
                resp_valid_m = if_b.resp_valid;
                resp_err_m   = if_b.resp_err;
                dout_m       = {32'd0, if_b.resp_dout};
            end
            2: begin
                req_ready_m  = if_c.req_ready;
                resp_valid_m = if_c.resp_valid;
                resp_err_m   = if_c.resp_err;
                dout_m       = if_c.resp_dout;
            end
            default: ;
        endcase
    end

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Present one request, then wait (bounded) for resp_valid and check the latency.
    task automatic issue(input int sel, input logic w, input logic [31:0] a,
                         input logic [63:0] d, input logic [7:0] be, input int lat);
        int n;
        sel_v = sel;
        check_val("req_ready before request", 64'(req_ready_m), 64'd1);
        req_valid_v = 1'b1;
        req_write_v = w;
        addr_v      = a;
        din_v       = d;
        be_v        = be;
        @(posedge clk);
        #1;
        req_valid_v = 1'b0;
        check_val("req_ready after accept", 64'(req_ready_m), 64'd0);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!resp_valid_m && n < 40);
        check_val("latency", 64'(n), 64'(lat));
    endtask

    task automatic finish_resp();
        resp_ready_v = 1'b1;
        @(posedge clk);
        #1;
        resp_ready_v = 1'b0;
        check_val("resp_valid after handshake", 64'(resp_valid_m), 64'd0);
        check_val("req_ready after handshake", 64'(req_ready_m), 64'd1);
        check_val("dout zero when idle", dout_m, 64'd0);
    endtask

    task automatic txn(input int sel, input logic w, input logic [31:0] a,
                       input logic [63:0] d, input logic [7:0] be, input int lat,
                       input logic [63:0] exp_d, input logic exp_err);
        issue(sel, w, a, d, be, lat);
        check_val("resp_dout", dout_m, exp_d);
        check_val("resp_err", 64'(resp_err_m), 64'(exp_err));
        finish_resp();
    endtask

    initial begin
        reset        = 1'b1;
        sel_v        = 0;
        req_valid_v  = 1'b0;
        req_write_v  = 1'b0;
        addr_v       = 32'd0;
        din_v        = 64'd0;
        be_v         = 8'd0;
        resp_ready_v = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_val("reset req_ready", 64'(req_ready_m), 64'd1);
        check_val("reset resp_valid", 64'(resp_valid_m), 64'd0);
        check_val("reset resp_dout", dout_m, 64'd0);
        check_val("reset resp_err", 64'(resp_err_m), 64'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Basic write then read
        txn(0, 1'b1, 32'h10, 64'hDEADBEEF, 8'h0F, 4, 64'd0, 1'b0);
        txn(0, 1'b0, 32'h10, 64'd0, 8'h00, 4, 64'hDEADBEEF, 1'b0);

        // Partial byte enables over a preloaded word
        txn(0, 1'b1, 32'h20, 64'h11223344, 8'h0F, 4, 64'd0, 1'b0);
        txn(0, 1'b1, 32'h20, 64'hAABBCCDD, 8'h05, 4, 64'd0, 1'b0);
        txn(0, 1'b0, 32'h20, 64'd0, 8'h00, 4, 64'h11BB33DD, 1'b0);

        // Backpressure: response held, stray requests ignored
        issue(0, 1'b0, 32'h10, 64'd0, 8'h00, 4);
        for (int i = 0; i < 6; i++) begin
            check_val("bp resp_valid", 64'(resp_valid_m), 64'd1);
            check_val("bp resp_dout", dout_m, 64'hDEADBEEF);
            check_val("bp req_ready", 64'(req_ready_m), 64'd0);
            req_valid_v = (i % 2 == 0);
            req_write_v = 1'b1;
            din_v       = 64'h0;
            be_v        = 8'h0F;
            @(posedge clk);
            #1;
        end
        req_valid_v = 1'b0;
        finish_resp();
        txn(0, 1'b0, 32'h10, 64'd0, 8'h00, 4, 64'hDEADBEEF, 1'b0);

        // Reset two cycles into a write: the write must never land
        txn(0, 1'b1, 32'h40, 64'h0, 8'h0F, 4, 64'd0, 1'b0);
        sel_v       = 0;
        req_valid_v = 1'b1;
        req_write_v = 1'b1;
        addr_v      = 32'h40;
        din_v       = 64'h12345678;
        be_v        = 8'h0F;
        @(posedge clk);
        #1;
        req_valid_v = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check_val("busy before reset", 64'(req_ready_m), 64'd0);
        #1;
        reset = 1'b1;
        #1;
        check_val("async reset req_ready", 64'(req_ready_m), 64'd1);
        check_val("async reset resp_valid", 64'(resp_valid_m), 64'd0);
        #3;
        reset = 1'b0;
        @(posedge clk);
        #1;
        txn(0, 1'b0, 32'h40, 64'd0, 8'h00, 4, 64'd0, 1'b0);

        // Reset while a read response is presented
        issue(0, 1'b0, 32'h10, 64'd0, 8'h00, 4);
        check_val("resp before reset", dout_m, 64'hDEADBEEF);
        #1;
        reset = 1'b1;
        #1;
        check_val("async reset clears dout", dout_m, 64'd0);
        check_val("async reset clears valid", 64'(resp_valid_m), 64'd0);
        check_val("async reset sets ready", 64'(req_ready_m), 64'd1);
        #3;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Depth-16 wrap at maximum latency, then a misaligned write
        txn(1, 1'b1, 32'h04, 64'hCAFEF00D, 8'h0F, 15, 64'd0, 1'b0);
        txn(1, 1'b0, 32'h44, 64'd0, 8'h00, 15, 64'hCAFEF00D, 1'b0);
`ifdef DMEM_MISALIGN_CHECK_EN
        txn(1, 1'b1, 32'h06, 64'h55555555, 8'h0F, 15, 64'd0, 1'b1);
        txn(1, 1'b0, 32'h04, 64'd0, 8'h00, 15, 64'hCAFEF00D, 1'b0);
`else
        txn(1, 1'b1, 32'h06, 64'h55555555, 8'h0F, 15, 64'd0, 1'b0);
        txn(1, 1'b0, 32'h04, 64'd0, 8'h00, 15, 64'h55555555, 1'b0);
`endif

        // 64-bit words with single-cycle latency
        txn(2, 1'b1, 32'h08, 64'h0123456789ABCDEF, 8'hFF, 1, 64'd0, 1'b0);
        txn(2, 1'b0, 32'h08, 64'd0, 8'h00, 1, 64'h0123456789ABCDEF, 1'b0);
        txn(2, 1'b1, 32'h08, 64'hFFFFFFFFFFFFFFFF, 8'hF0, 1, 64'd0, 1'b0);
        txn(2, 1'b0, 32'h08, 64'd0, 8'h00, 1, 64'hFFFFFFFF89ABCDEF, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
